adc_event_log: RTL

Event capture stage placed directly downstream of the ADC threshold event detector. On every detector interrupt pulse it stores the detector's `adc_event` and `adc_event_seq` outputs, plus an optional capture timestamp, in a small synchronous FIFO. Software drains the FIFO through a one-cycle read handshake. The block also raises a level interrupt based on a fill threshold and overflow status.

---
 rtl/adc_pkg.sv | 35 +++
 rtl/adc_event_log_if.sv | 33 +++
 rtl/adc_event_ram.sv | 41 ++++
 rtl/adc_event_log.sv | 138 +++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC event widths and capture entry type
//
// Purpose: constants and the packed FIFO entry shared by the ADC event
// detector and the event log.
// Contents: ADC_DATA_W, ADC_SEQ_W, ADC_TS_W, derived entry widths,
// adc_evt_entry_t {ts, seq, evt}, and the adc_pack_entry() helper.
package adc_pkg;

  localparam int ADC_DATA_W  = 10;
  localparam int ADC_SEQ_W   = 6;
  localparam int ADC_TS_W    = 16;
  // Entry without timestamp: {seq, evt}
  localparam int ADC_TAG_W   = ADC_SEQ_W + ADC_DATA_W;
  // Entry with timestamp: {ts, seq, evt}
  localparam int ADC_ENTRY_W = ADC_TS_W + ADC_TAG_W;

  typedef struct packed {
    logic [ADC_TS_W-1:0]   ts;
    logic [ADC_SEQ_W-1:0]  seq;
    logic [ADC_DATA_W-1:0] evt;
  } adc_evt_entry_t;

  function automatic adc_evt_entry_t adc_pack_entry(
    input logic [ADC_TS_W-1:0]   ts,
    input logic [ADC_SEQ_W-1:0]  seq,
    input logic [ADC_DATA_W-1:0] evt
  );
    adc_evt_entry_t e;
    e.ts  = ts;
    e.seq = seq;
    e.evt = evt;
    return e;
  endfunction

endpackage

// File: rtl/adc_event_log_if.sv
// rtl/adc_event_log_if.sv - event push and read-drain handshake bundle
//
// Purpose: groups the detector push strobe/payload and the software read
// handshake of adc_event_log.
// Signals:
//   adc_event      [9:0]  event code from the detector
//   adc_event_seq  [5:0]  sequence tag from the detector
//   adc_event_intr        push strobe, one event per high cycle
//   rd_req                pop request, one pulse per entry
//   rd_data       [31:0]  {ts, seq, evt}, valid while rd_valid is high
//   rd_valid              one-cycle read data strobe
// Modports: master = detector/software side, slave = event log.
interface adc_event_log_if;
  import adc_pkg::*;

  logic [ADC_DATA_W-1:0]  adc_event;
  logic [ADC_SEQ_W-1:0]   adc_event_seq;
  logic                   adc_event_intr;
  logic                   rd_req;
  logic [ADC_ENTRY_W-1:0] rd_data;
  logic                   rd_valid;

  modport master (
    output adc_event, adc_event_seq, adc_event_intr, rd_req,
    input  rd_data, rd_valid
  );

  modport slave (
    input  adc_event, adc_event_seq, adc_event_intr, rd_req,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/adc_event_ram.sv
// rtl/adc_event_ram.sv - FIFO storage: one write port, one registered read port
//
// Purpose: DEPTH x WIDTH register array backing the event log FIFO.
// Ports:
//   clk, rstn  clock and synchronous active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr         read request; rdata updates on the following edge
//   rdata             registered read data, holds when re is low
// The array itself is not reset. A read and write to the same address in
// one cycle returns the old contents, which the full-FIFO push+pop relies on.
module adc_event_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/adc_event_log.sv
// rtl/adc_event_log.sv - ADC event capture FIFO with threshold/overflow irq
//
// Purpose: captures {ts, adc_event_seq, adc_event} on every detector push
// strobe into a DEPTH-entry FIFO that software drains one entry per rd_req.
// Optional feature macro: ADC_EVENT_LOG_TSTAMP_EN (adds a free-running
// 16-bit capture timestamp; otherwise rd_data[31:16] is 0).
// Parameters: DEPTH (power of two, 2..64), IRQ_THRESH (1..DEPTH).
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   bus        adc_event_log_if.slave: push payload/strobe, rd_req/rd_data/rd_valid
//   clr        synchronous flush of FIFO and status (timestamp keeps running)
//   irq_en     interrupt mask
//   count      occupancy, log2(DEPTH)+1 bits
//   empty/full occupancy flags
//   ovf        sticky overflow, drop_cnt saturating dropped-event count
//   irq        registered level interrupt
module adc_event_log
  import adc_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int IRQ_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  adc_event_log_if.slave         bus,
  input  logic                   clr,
  input  logic                   irq_en,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic [7:0]             drop_cnt,
  output logic                   irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

`ifdef ADC_EVENT_LOG_TSTAMP_EN
  localparam int ENTRY_W = ADC_ENTRY_W;
`else
  localparam int ENTRY_W = ADC_TAG_W;
`endif

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               rd_valid_q;
  logic               pop_ok;
  logic               push_ok;
  logic               drop;
  logic               irq_next;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // clr wins over any push/pop in the same cycle; a push lost to clr is not a drop.
  assign pop_ok  = rstn && !clr && bus.rd_req && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign push_ok = rstn && !clr && bus.adc_event_intr && (!full || pop_ok);
  assign drop    = rstn && !clr && bus.adc_event_intr && full && !pop_ok;

  // irq is registered from the current (pre-edge) state, so it trails count by one cycle.
  assign irq_next = irq_en && ((count >= PW'(IRQ_THRESH)) || ovf);

`ifdef ADC_EVENT_LOG_TSTAMP_EN
  logic [ADC_TS_W-1:0] ts;

  // Free-running capture time; only reset clears it, clr does not.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ts <= '0;
    end else begin
      ts <= ts + ADC_TS_W'(1);
    end
  end

  assign wdata       = adc_pack_entry(ts, bus.adc_event_seq, bus.adc_event);
  assign bus.rd_data = rdata;
`else
  assign wdata       = {bus.adc_event_seq, bus.adc_event};
  assign bus.rd_data = {{ADC_TS_W{1'b0}}, rdata};
`endif

  assign bus.rd_valid = rd_valid_q;

  adc_event_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .re    (pop_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf        <= 1'b0;
      drop_cnt   <= '0;
      rd_valid_q <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq <= irq_next;
      if (clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        ovf        <= 1'b0;
        drop_cnt   <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop_ok;
        if (push_ok) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (drop) begin
          ovf <= 1'b1;
          if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule
